// File: rtl/block_xor_summer.sv
// block_xor_summer: XOR of a reference and candidate census block followed by a
// four-stage saturating popcount pipeline. Sideband travels with each entry.

// 16-bit slice popcount, one instance per slice.
module popcnt16 (
   input  logic [15:0] bits,
   output logic [4:0]  cnt
);
   // Count set bits of one slice.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < 16; i++) cnt += 5'(bits[i]);
   end
endmodule

module block_xor_summer #(
   parameter int blk_size = 256,
   parameter int sum_w    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic [blk_size-1:0] ref_blk,
   input  logic [blk_size-1:0] cand_blk,
   input  logic [15:0]         in_coords,
   input  logic [15:0]         in_blk_index,
   input  logic                in_valid,
   output logic [blk_size-1:0] xors,
   output logic [sum_w-1:0]    sum,
   output logic [15:0]         out_coords,
   output logic [15:0]         blk_index_o,
   output logic                sum_valid,
   output logic [15:0]         sat_count
);
   localparam int NS = blk_size / 16;
   localparam int NG = blk_size / 64;
   localparam int TW = $clog2(blk_size) + 1;
   localparam logic [31:0] MAXV = (32'd1 << sum_w) - 32'd1;

   typedef struct packed {
      logic [blk_size-1:0] x;
      logic [15:0]         coords;
      logic [15:0]         idx;
   } ent_t;

   logic [4:1]          vld_pipe;
   ent_t                s1, s2, s3;
   logic [NS-1:0][4:0]  cnt_c, cnt_q;
   logic [NG-1:0][6:0]  grp_c, grp_q;
   logic [TW-1:0]       total_c;
   logic                over_c;

   // Valid shift register; flush kills every in-flight entry and the current input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   vld_pipe <= '0;
      else if (flush) vld_pipe <= '0;
      else            vld_pipe <= {vld_pipe[3:1], in_valid};
   end

   // S1: xor plus sideband, loaded only for a valid input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      s1 <= '0;
      else if (in_valid) s1 <= '{x: ref_blk ^ cand_blk, coords: in_coords, idx: in_blk_index};
   end

   for (genvar g = 0; g < NS; g++) begin : g_pc
      popcnt16 u_pc (.bits(s1.x[g*16 +: 16]), .cnt(cnt_c[g]));
   end

   // S2: per-slice counts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2    <= '0;
         cnt_q <= '0;
      end else if (vld_pipe[1]) begin
         s2    <= s1;
         cnt_q <= cnt_c;
      end
   end

   // Sum each group of four slice counts (0..64).
   always_comb begin
      grp_c = '0;
      for (int g = 0; g < NG; g++)
         for (int j = 0; j < 4; j++) grp_c[g] += 7'(cnt_q[g*4+j]);
   end

   // S3: group partials.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s3    <= '0;
         grp_q <= '0;
      end else if (vld_pipe[2]) begin
         s3    <= s2;
         grp_q <= grp_c;
      end
   end

   // Full total is wide enough for blk_size itself, so it never wraps.
   always_comb begin
      total_c = '0;
      for (int g = 0; g < NG; g++) total_c += TW'(grp_q[g]);
      over_c = 32'(total_c) > MAXV;
   end

   // S4: saturated sum and delayed sideband.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xors        <= '0;
         sum         <= '0;
         out_coords  <= '0;
         blk_index_o <= '0;
      end else if (vld_pipe[3]) begin
         xors        <= s3.x;
         sum         <= over_c ? '1 : sum_w'(total_c);
         out_coords  <= s3.coords;
         blk_index_o <= s3.idx;
      end
   end

   // Count emitted results that saturated; flush does not clear it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sat_count <= '0;
      else if (vld_pipe[3] && !flush && over_c && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end

   assign sum_valid = vld_pipe[4];
endmodule

// File: tb/tb_block_xor_summer.sv
// Scoreboard bench for block_xor_summer: driver pushes expected results,
// monitor pops and compares on every sum_valid.
module tb_block_xor_summer;
   localparam int BS = 256;
   localparam int SW = 8;

   logic          clk, reset_n, flush, in_valid;
   logic [BS-1:0] ref_blk, cand_blk, xors;
   logic [15:0]   in_coords, in_blk_index, out_coords, blk_index_o, sat_count;
   logic [SW-1:0] sum;
   logic          sum_valid;

   block_xor_summer #(.blk_size(BS), .sum_w(SW)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .ref_blk(ref_blk), .cand_blk(cand_blk),
      .in_coords(in_coords), .in_blk_index(in_blk_index), .in_valid(in_valid),
      .xors(xors), .sum(sum), .out_coords(out_coords), .blk_index_o(blk_index_o),
      .sum_valid(sum_valid), .sat_count(sat_count)
   );

   typedef struct {
      logic [BS-1:0] x;
      logic [15:0]   c;
      logic [15:0]   i;
      int            cnt;
      int            cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0, failures = 0;
   int   cyc = 0, pulses = 0, accepted = 0;
   int   exp_sat = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [BS-1:0] act, logic [BS-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [BS-1:0] rnd_blk();
      logic [BS-1:0] r;
      for (int k = 0; k < BS/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [BS-1:0] ones_n(int n);
      logic [BS-1:0] m = '0;
      for (int k = 0; k < n; k++) m[k] = 1'b1;
      return m;
   endfunction

   // One cycle of stimulus; a surviving valid entry gets its expected result queued.
   task automatic drive(bit v, logic [BS-1:0] r, logic [BS-1:0] c, logic [15:0] co,
                        logic [15:0] ix, bit push, bit fl = 1'b0);
      exp_t e;
      @(negedge clk);
      in_valid = v; ref_blk = r; cand_blk = c; in_coords = co; in_blk_index = ix; flush = fl;
      if (v && push && !fl) begin
         e.x = r ^ c; e.c = co; e.i = ix; e.cnt = $countones(r ^ c); e.cyc = cyc + 4;
         q.push_back(e);
         accepted++;
      end
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 16'h0, 16'h0, 1'b0);
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 50) begin idle(1); t++; end
      chk("drain_timeout", BS'(q.size()), '0);
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && sum_valid) begin
         pulses++;
         if (q.size() == 0) chk("unexpected_valid", BS'(1), BS'(0));
         else begin
            e = q.pop_front();
            if (e.cnt > 255 && exp_sat < 16'hFFFF) exp_sat++;
            chk("sum", BS'(sum), BS'((e.cnt > 255) ? 255 : e.cnt));
            chk("xors", xors, e.x);
            chk("out_coords", BS'(out_coords), BS'(e.c));
            chk("blk_index_o", BS'(blk_index_o), BS'(e.i));
            chk("latency", BS'(cyc), BS'(e.cyc));
            chk("sat_count", BS'(sat_count), BS'(exp_sat));
         end
      end
   end

   initial begin
      logic [BS-1:0] r;
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      ref_blk = '0; cand_blk = '0; in_coords = '0; in_blk_index = '0;
      #3;
      chk("rst_sum_valid", BS'(sum_valid), '0);
      chk("rst_sum", BS'(sum), '0);
      chk("rst_xors", xors, '0);
      chk("rst_coords", BS'(out_coords), '0);
      chk("rst_idx", BS'(blk_index_o), '0);
      chk("rst_sat", BS'(sat_count), '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // identical blocks -> zero sum
      drive(1'b1, '1, '1, 16'h0003, 16'h1000, 1'b1);
      idle(1);
      // saturation boundary: 256 bits saturates, 255 bits does not count
      drive(1'b1, '0, '1, 16'h0011, 16'h0001, 1'b1);
      drive(1'b1, '0, ones_n(255), 16'h0012, 16'h0002, 1'b1);
      idle(1);
      // back-to-back burst with k bits set
      for (int k = 0; k < 16; k++) drive(1'b1, '0, ones_n(k), 16'(k), 16'(k + 32), 1'b1);
      drain();

      // three inputs killed by a flush; later input emits normally
      for (int k = 0; k < 3; k++) drive(1'b1, rnd_blk(), rnd_blk(), 16'hBAD0, 16'hBAD0, 1'b0);
      drive(1'b1, rnd_blk(), rnd_blk(), 16'hBAD1, 16'hBAD1, 1'b0, 1'b1);
      idle(1);
      drive(1'b1, '0, ones_n(77), 16'h0505, 16'h0606, 1'b1);
      drain();
      idle(2);

      // asynchronous reset mid-stream with two entries in flight
      drive(1'b1, rnd_blk(), rnd_blk(), 16'hDEAD, 16'hDEAD, 1'b0);
      drive(1'b1, rnd_blk(), rnd_blk(), 16'hDEAD, 16'hDEAD, 1'b0);
      drive(1'b0, '0, '0, 16'h0, 16'h0, 1'b0);
      @(posedge clk);
      #2 reset_n = 1'b0;
      q.delete(); exp_sat = 0;
      #1;
      chk("mid_rst_sum_valid", BS'(sum_valid), '0);
      chk("mid_rst_sum", BS'(sum), '0);
      chk("mid_rst_xors", xors, '0);
      chk("mid_rst_coords", BS'(out_coords), '0);
      chk("mid_rst_idx", BS'(blk_index_o), '0);
      chk("mid_rst_sat", BS'(sat_count), '0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(5);
      drive(1'b1, '0, ones_n(200), 16'h0707, 16'h0808, 1'b1);
      drain();

      // randomized alternating traffic
      for (int n = 0; n < 10000; n++) begin
         r = rnd_blk();
         case ($urandom_range(0, 7))
            0:       drive(1'b1, r, ~r, 16'($urandom), 16'($urandom), 1'b1);
            1:       drive(1'b1, r, r, 16'($urandom), 16'($urandom), 1'b1);
            2:       drive(1'b1, r, r ^ ones_n($urandom_range(240, 256)), 16'($urandom), 16'($urandom), 1'b1);
            default: drive(1'b1, r, rnd_blk(), 16'($urandom), 16'($urandom), 1'b1);
         endcase
         drive(1'b0, rnd_blk(), rnd_blk(), 16'($urandom), 16'($urandom), 1'b0);
      end
      drain();
      idle(4);
      chk("pulse_count", BS'(pulses), BS'(accepted));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/block_xor_summer.md
BLOCK_XOR_SUMMER -- requirements
Module: block_xor_summer

Interface
REQ-001 The block SHALL have parameter blk_size, default 256, meaning census bits per block; legal values are multiples of 64.
REQ-002 The block SHALL have parameter sum_w, default 8, meaning output sum width; the sum saturates at 2^sum_w-1.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be clk and reset_n, and all outputs SHALL clear immediately on reset_n low without waiting for a clk edge.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous flush; kills all in-flight entries.
REQ-007 ref_blk  input  blk_size  reference-image census block.
REQ-008 cand_blk  input  blk_size  candidate census block at in_coords.
REQ-009 in_coords  input  16  candidate offset, [15:8] vertical, [7:0] horizontal.
REQ-010 in_blk_index  input  16  reference block index; [11:0]==0 marks the first block of a row.
REQ-011 in_valid  input  1  ref_blk, cand_blk and sideband are valid this cycle.
REQ-012 xors  output  blk_size  ref_blk XOR cand_blk, delayed to align with sum.
REQ-013 sum  output  sum_w  saturated popcount of xors.
REQ-014 out_coords  output  16  in_coords, delayed.
REQ-015 blk_index_o  output  16  in_blk_index, delayed.
REQ-016 sum_valid  output  1  single-cycle qualifier for xors/sum/out_coords/blk_index_o.
REQ-017 sat_count  output  16  number of results emitted with saturated sum since reset.

Function
REQ-018 The pipeline SHALL have exactly four register stages (S1..S4); an input accepted at edge N SHALL appear on the outputs with sum_valid=1 after edge N+3 and be held for one cycle only.
REQ-019 S1 SHALL register xor = ref_blk ^ cand_blk together with in_coords, in_blk_index and in_valid.
REQ-020 S2 SHALL register one popcount per 16-bit slice of the S1 xor (blk_size/16 counts, 5 bits each, range 0..16).
REQ-021 S3 SHALL register sums of groups of four S2 counts (7 bits each, range 0..64).
REQ-022 S4 SHALL add all S3 partials at width clog2(blk_size)+1 bits and register sum = min(total, 2^sum_w-1); no wrap-around SHALL ever occur.
REQ-023 xors, out_coords and blk_index_o SHALL travel with their own valid bit through every stage; sideband SHALL never mix between entries.
REQ-024 There SHALL be no backpressure: in_valid SHALL be accepted every cycle, back-to-back, at 1 entry per clock.
REQ-025 Data registers SHALL update only when the valid bit entering that stage is 1; valid bits SHALL update every cycle.
REQ-026 When flush=1 at an edge, all stage valid bits SHALL clear at that edge, any input presented that cycle SHALL be discarded, and sum_valid SHALL be 0 for the next three cycles unless new inputs are accepted after flush deasserts.
REQ-027 sat_count SHALL increment by 1 on each edge where S4 loads a valid entry whose unsaturated total exceeds 2^sum_w-1, and SHALL saturate at 16'hFFFF.
REQ-028 flush SHALL NOT clear sat_count.
REQ-029 With the default parameters, the maximum total 256 SHALL produce sum=255 and increment sat_count; a total of 255 SHALL produce sum=255 and SHALL NOT increment sat_count.

Reset
REQ-030 While reset_n=0, all valid bits, sum_valid, sum, xors, out_coords, blk_index_o and sat_count SHALL be 0.
REQ-031 Assertion of reset_n in mid-stream SHALL discard every in-flight entry; the first input accepted after release SHALL emit after exactly four edges.

Verification
REQ-032 Identical ref_blk and cand_blk of all ones, in_coords=16'h0003, in_blk_index=16'h1000 -> three edges later: sum=0, xors=0, out_coords=16'h0003, blk_index_o=16'h1000, sum_valid=1 for one cycle.
REQ-033 ref_blk=0 and cand_blk=all ones -> sum=255 and sat_count 0->1; ref_blk=0 and cand_blk with 255 bits set -> sum=255 and sat_count unchanged.
REQ-034 Burst of 16 back-to-back inputs whose cand_blk has k bits set (k=0..15) and in_coords=k -> 16 consecutive sum_valid cycles with sum=k and out_coords=k, in order.
REQ-035 Three valid inputs, then flush=1 in the cycle after the third -> none of the three emits; an input accepted two cycles later emits normally with correct sum.
REQ-036 reset_n pulled low asynchronously between clk edges with two entries in flight -> outputs and sat_count read 0 before the next edge; after release, no stale sum_valid appears.
REQ-037 Alternate in_valid 1/0 with random blocks against a reference popcount model for 10k entries -> every emitted sum, xors and sideband matches, and the count of sum_valid pulses equals the count of accepted inputs.
